// File: rtl/request_unit.sv
// ============================================================================
// Module   : request_unit
// Purpose  : Sequences instruction fetch, one data access per instruction and
//            the PC retire pulse between the datapath and memory controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module request_unit (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] pc,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic        Halt,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [31:0] imemload,
  input  logic [31:0] dmemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic [31:0] Instr,
  output logic [31:0] dload,
  output logic        PCEn,
  output logic        halt,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    IFETCH  = 2'd0,
    EXEC    = 2'd1,
    DACCESS = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_instr;
  logic [31:0] r_dload;
  logic [31:0] r_instret;
  logic        w_imem_ren;
  logic        w_dmem_ren;
  logic        w_dmem_wen;
  logic        w_pc_en;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IFETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Write wins when a malformed instruction decodes both MemRd and MemWr.
  always_comb begin
    w_next_state = r_state;
    w_imem_ren   = 1'b0;
    w_dmem_ren   = 1'b0;
    w_dmem_wen   = 1'b0;
    w_pc_en      = 1'b0;
    case (r_state)
      IFETCH: begin
        w_imem_ren = 1'b1;
        if (ihit) begin
          w_next_state = EXEC;
        end
      end
      EXEC: begin
        if (Halt) begin
          w_next_state = HALTED;
        end else if (MemWr || MemRd) begin
          w_next_state = DACCESS;
        end else begin
          w_pc_en      = 1'b1;
          w_next_state = IFETCH;
        end
      end
      DACCESS: begin
        w_dmem_wen = MemWr;
        w_dmem_ren = MemRd & ~MemWr;
        if (dhit) begin
          w_pc_en      = 1'b1;
          w_next_state = IFETCH;
        end
      end
      HALTED: begin
        w_next_state = HALTED;
      end
      default: begin
        w_next_state = IFETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_instr <= 32'd0;
    end else if (r_state == IFETCH && ihit) begin
      r_instr <= imemload;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_dload <= 32'd0;
    end else if (r_state == DACCESS && dhit && MemRd && !MemWr) begin
      r_dload <= dmemload;
    end
  end

  // Natural 32-bit wrap from all-ones back to zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_instret <= 32'd0;
    end else if (w_pc_en) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  assign imemREN   = w_imem_ren;
  assign imemaddr  = pc;
  assign dmemREN   = w_dmem_ren;
  assign dmemWEN   = w_dmem_wen;
  assign dmemaddr  = daddr;
  assign dmemstore = dstore;
  assign Instr     = r_instr;
  assign dload     = r_dload;
  assign PCEn      = w_pc_en;
  assign halt      = (r_state == HALTED);
  assign instret   = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_request_unit.sv
// ============================================================================
// Module   : tb_request_unit
// Purpose  : Directed self-checking bench for request_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_request_unit;

  logic        clk;
  logic        n_rst;
  logic [31:0] pc;
  logic        MemRd;
  logic        MemWr;
  logic        Halt;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] imemload;
  logic [31:0] dmemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic [31:0] Instr;
  logic [31:0] dload;
  logic        PCEn;
  logic        halt;
  logic [31:0] instret;

  int checks;
  int failures;

  request_unit dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .pc        (pc),
    .MemRd     (MemRd),
    .MemWr     (MemWr),
    .Halt      (Halt),
    .daddr     (daddr),
    .dstore    (dstore),
    .ihit      (ihit),
    .dhit      (dhit),
    .imemload  (imemload),
    .dmemload  (dmemload),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .Instr     (Instr),
    .dload     (dload),
    .PCEn      (PCEn),
    .halt      (halt),
    .instret   (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n_rst    = 1'b0;
    pc       = 32'h0000_0040;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    Halt     = 1'b0;
    daddr    = 32'd0;
    dstore   = 32'd0;
    ihit     = 1'b1;
    dhit     = 1'b0;
    imemload = 32'h0022_1820;
    dmemload = 32'd0;

    // Reset with ihit asserted
    #3;
    check("rst_imemREN", {31'd0, imemREN}, 32'd1);
    check("rst_imemaddr", imemaddr, 32'h0000_0040);
    check("rst_Instr", Instr, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_PCEn", {31'd0, PCEn}, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_dmem", {30'd0, dmemREN, dmemWEN}, 32'd0);
    @(posedge clk);
    #2;
    check("rst_hold_Instr", Instr, 32'd0);
    n_rst = 1'b1;

    // First fetch and ALU instruction
    tick();
    check("fetch_Instr", Instr, 32'h0022_1820);
    check("exec_imemREN", {31'd0, imemREN}, 32'd0);
    ihit = 1'b0;
    #1;
    check("alu_PCEn", {31'd0, PCEn}, 32'd1);
    check("alu_nodata", {30'd0, dmemREN, dmemWEN}, 32'd0);
    check("alu_instret_pre", instret, 32'd0);
    tick();
    check("alu_instret", instret, 32'd1);
    check("alu_PCEn_off", {31'd0, PCEn}, 32'd0);
    check("alu_refetch", {31'd0, imemREN}, 32'd1);

    // Load with three wait states
    ihit     = 1'b1;
    pc       = 32'h0000_0044;
    imemload = 32'h8C01_0100;
    tick();
    ihit     = 1'b0;
    MemRd    = 1'b1;
    daddr    = 32'h0000_0100;
    dmemload = 32'hDEAD_BEEF;
    #1;
    check("ld_exec_PCEn", {31'd0, PCEn}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 3);
      #1;
      check("ld_dmemREN", {31'd0, dmemREN}, 32'd1);
      check("ld_dmemaddr", dmemaddr, 32'h0000_0100);
      check("ld_imemREN", {31'd0, imemREN}, 32'd0);
      check("ld_PCEn", {31'd0, PCEn}, (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check("ld_dload", dload, 32'hDEAD_BEEF);
    check("ld_instret", instret, 32'd2);
    check("ld_after_PCEn", {31'd0, PCEn}, 32'd0);
    check("ld_after_dmemREN", {31'd0, dmemREN}, 32'd0);
    dhit  = 1'b0;
    MemRd = 1'b0;

    // Store with immediate dhit
    ihit     = 1'b1;
    imemload = 32'hAC02_0000;
    tick();
    ihit   = 1'b0;
    MemWr  = 1'b1;
    dstore = 32'h1234_5678;
    tick();
    dhit = 1'b1;
    #1;
    check("st_dmemWEN", {31'd0, dmemWEN}, 32'd1);
    check("st_dmemREN", {31'd0, dmemREN}, 32'd0);
    check("st_dmemstore", dmemstore, 32'h1234_5678);
    check("st_PCEn", {31'd0, PCEn}, 32'd1);
    tick();
    check("st_dload", dload, 32'hDEAD_BEEF);
    check("st_instret", instret, 32'd3);
    MemWr = 1'b0;
    #1;

    // Stray dhit during IFETCH
    check("stray_PCEn", {31'd0, PCEn}, 32'd0);
    check("stray_dmem", {30'd0, dmemREN, dmemWEN}, 32'd0);
    tick();
    check("stray_imemREN", {31'd0, imemREN}, 32'd1);
    check("stray_instret", instret, 32'd3);
    check("stray_dload", dload, 32'hDEAD_BEEF);

    // Both MemRd and MemWr set; dhit collides with a pending ihit
    dhit     = 1'b0;
    ihit     = 1'b1;
    imemload = 32'hFFFF_0001;
    tick();
    ihit  = 1'b0;
    MemRd = 1'b1;
    MemWr = 1'b1;
    tick();
    check("both_dmemWEN", {31'd0, dmemWEN}, 32'd1);
    check("both_dmemREN", {31'd0, dmemREN}, 32'd0);
    check("both_wait_PCEn", {31'd0, PCEn}, 32'd0);
    tick();
    check("both_wait_WEN", {31'd0, dmemWEN}, 32'd1);
    dhit     = 1'b1;
    ihit     = 1'b1;
    imemload = 32'h0000_0002;
    #1;
    check("coll_PCEn", {31'd0, PCEn}, 32'd1);
    check("coll_imemREN", {31'd0, imemREN}, 32'd0);
    tick();
    check("coll_Instr", Instr, 32'hFFFF_0001);
    check("coll_instret", instret, 32'd4);
    check("both_dload", dload, 32'hDEAD_BEEF);
    dhit  = 1'b0;
    MemRd = 1'b0;
    MemWr = 1'b0;
    tick();
    check("coll_fetch", Instr, 32'h0000_0002);

    // Halt, with a memory op also decoded
    ihit  = 1'b0;
    Halt  = 1'b1;
    MemRd = 1'b1;
    #1;
    check("halt_exec_PCEn", {31'd0, PCEn}, 32'd0);
    tick();
    check("halt_set", {31'd0, halt}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      ihit = i[0];
      dhit = ~i[0];
      Halt = 1'b0;
      #1;
      check("halt_reqs", {28'd0, imemREN, dmemREN, dmemWEN, PCEn}, 32'd0);
      check("halt_sticky", {31'd0, halt}, 32'd1);
      tick();
    end
    check("halt_instret", instret, 32'd4);
    n_rst = 1'b0;
    #1;
    check("halt_rst_halt", {31'd0, halt}, 32'd0);
    check("halt_rst_imemREN", {31'd0, imemREN}, 32'd1);
    check("halt_rst_instret", instret, 32'd0);
    n_rst = 1'b1;
    MemRd = 1'b0;
    dhit  = 1'b0;

    // instret wrap
    ihit = 1'b1;
    tick();
    ihit = 1'b0;
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    #1;
    check("wrap_pre", instret, 32'hFFFF_FFFF);
    check("wrap_PCEn", {31'd0, PCEn}, 32'd1);
    tick();
    check("wrap_instret", instret, 32'd0);

    // Reset in the middle of a data access
    ihit = 1'b1;
    tick();
    ihit  = 1'b0;
    MemRd = 1'b1;
    tick();
    check("mid_dmemREN", {31'd0, dmemREN}, 32'd1);
    tick();
    check("mid_wait_dmemREN", {31'd0, dmemREN}, 32'd1);
    #2;
    n_rst = 1'b0;
    dhit  = 1'b1;
    #1;
    check("mid_rst_dmemREN", {31'd0, dmemREN}, 32'd0);
    check("mid_rst_PCEn", {31'd0, PCEn}, 32'd0);
    check("mid_rst_imemREN", {31'd0, imemREN}, 32'd1);
    tick();
    check("mid_rst_instret", instret, 32'd0);
    n_rst = 1'b1;
    dhit  = 1'b0;
    MemRd = 1'b0;
    tick();
    check("mid_after_instret", instret, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
